coef_mult_pipe: RTL and testbench
=================================

Name: coef_mult_pipe

Overview:
- Parametrised successor of the single-coefficient multiply stage in the quadratic solver datapath (Y = Ax^2 + Bx + C).
- Computes o_y = COEF * i_x through a LATENCY-deep pipeline with per-stage valid bits and full valid/ready backpressure, so bubbles collapse.
- The coefficient is runtime-loadable. One instance serves any of the A/B/C product terms; it sits between the NoC input adapter and the adder stage.

Parameters:
- WIDTH, 16, input operand width (unsigned).
- OUT_WIDTH, 16, output result width; legal range 1..2*WIDTH.
- LATENCY, 2, number of register stages from accept to output; minimum 1.
- COEF_INIT, 16'd101, coefficient value after reset (WIDTH bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_x  in  WIDTH  operand
- i_valid_in  in  1  operand valid
- i_ready_out  out  1  block can accept an operand this cycle
- i_coef  in  WIDTH  new coefficient value
- i_coef_load  in  1  load i_coef into the coefficient register
- o_y  out  OUT_WIDTH  product
- o_valid_out  out  1  o_y valid
- o_ready_in  in  1  downstream accepts
- o_busy  out  1  at least one stage holds valid data

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, stage data 0, coef = COEF_INIT. Outputs o_y=0, o_valid_out=0, o_busy=0. i_ready_out=1 once reset is released.
- Reset asserted mid-operation drops all in-flight data immediately. Nothing is replayed.
- Transfer rule: a transfer occurs on a clock edge where valid&ready are both high, on either side of the block.
- Stage k (0..LATENCY-1) may load when it holds no valid data or stage k+1 loads that cycle. The last stage may load when it is empty or o_ready_in=1.
  - The ready chain is combinational.
  - i_ready_out is the stage-0 load condition.
  - o_ready_in low with every stage full gives i_ready_out low.
- Stage 0 captures the product of i_x and the current coef register on an input transfer. Later stages only delay the data. o_y and o_valid_out come from the last stage register.
- Latency: with no stall, an operand accepted at edge N gives o_valid_out=1 after edge N+LATENCY-1 (visible in the cycle following that edge), i.e. LATENCY register stages. Throughput is one result per cycle.
- Stall: o_valid_out and o_y stay stable while o_ready_in=0. Results are never lost or reordered.
- Arithmetic: unsigned 2*WIDTH full product. Without the optional feature it is truncated to the low OUT_WIDTH bits (wrap).
- Coefficient load:
  - i_coef_load=1 updates coef at that edge.
  - An operand accepted on the same edge uses the OLD coef.
  - Later operands use the new coef.
  - In-flight items are unaffected because the product is fixed at stage 0.
- o_busy = OR of all stage valid bits.
- If i_valid_in=1 while i_ready_out=0, no transfer occurs. The source must hold i_x.

Optional Feature:
- Macro: COEF_MULT_SAT_EN
- Defined: if any product bit above OUT_WIDTH-1 is set, o_y = all ones (saturate).
- Undefined: o_y wraps to the low OUT_WIDTH bits.
- With OUT_WIDTH = 2*WIDTH both builds behave identically.

Decomposition:
- Package quad_pkg:
  - DATA_WIDTH=16
  - COEF_A=101, COEF_B=59, COEF_C=76
  - typedef data_t (logic [DATA_WIDTH-1:0])
  - typedef prod_t (logic [2*DATA_WIDTH-1:0])
- Sub-module pipe_stage: one register stage with its data register, valid bit and ready computation.
- coef_mult_pipe instantiates LATENCY pipe_stage copies in a generate loop, plus the coef register and the multiply/width logic.

Test Plan:
- Default params, o_ready_in=1, i_x=3 for one cycle. Expect o_y=303 with o_valid_out pulsed once, 2 cycles after accept.
- Stream x=1,2,3,4 back-to-back with o_ready_in=1. Expect outputs 101,202,303,404 in consecutive cycles and i_ready_out constantly 1.
- LATENCY=3, o_ready_in=0, offer 5 operands.
  - Expect exactly 3 accepted, then i_ready_out=0 and o_y held stable.
  - Raise o_ready_in and expect results in order with no loss.
- x=1000, WIDTH=OUT_WIDTH=16:
  - Without COEF_MULT_SAT_EN, expect o_y=35464.
  - With COEF_MULT_SAT_EN, expect o_y=65535.
- Pulse i_coef_load with i_coef=59 on the same edge x=2 is accepted, then x=2 again next cycle. Expect o_y=202, then 118.
- Fill the pipeline, then assert rst_n=0 asynchronously mid-cycle. Expect o_valid_out=0 and o_busy=0 immediately; after release, coef=101 and no stale outputs appear.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadratic solver datapath (Y = Ax^2 + Bx + C).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package quad_pkg;

    localparam int DATA_WIDTH = 16;

    // Default coefficients for the A, B and C product terms.
    localparam int COEF_A = 101;
    localparam int COEF_B = 59;
    localparam int COEF_C = 76;

    typedef logic [DATA_WIDTH-1:0]   data_t;
    typedef logic [2*DATA_WIDTH-1:0] prod_t;

endpackage

// File: rtl/pipe_stage.sv
// One register stage of a valid/ready pipeline: data register, valid bit, load condition.
// Latency: 1 cycle from d_dat/d_vld to q_dat/q_vld.
// Backpressure: loads when empty or when the next stage loads this cycle (load is combinational).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   d_dat/d_vld  data and valid offered by the previous stage (or the input)
//   nxt_load     next stage (or the downstream consumer) takes this stage's data this cycle
//   load         this stage captures d_dat/d_vld at the coming edge
//   q_dat/q_vld  registered data and valid
module pipe_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_dat,
    input  logic         d_vld,
    input  logic         nxt_load,
    output logic         load,
    output logic         q_vld,
    output logic [W-1:0] q_dat
);

    // An empty stage can always take something; a full one only if its
    // content moves on in the same cycle.
    assign load = !q_vld || nxt_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld <= 1'b0;
            q_dat <= '0;
        end else if (load) begin
            q_vld <= d_vld;
            // Bubbles leave the data register untouched.
            if (d_vld) begin
                q_dat <= d_dat;
            end
        end
    end

endmodule

// File: rtl/coef_mult_pipe.sv
// Multiplies an unsigned operand by a runtime-loadable coefficient: o_y = coef * i_x.
// Latency: LATENCY register stages from input transfer to o_valid_out; one result per cycle.
// Backpressure: combinational ready chain, bubbles collapse; i_ready_out low only when every stage is full and o_ready_in is low.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_x, i_valid_in, i_ready_out   operand input handshake
//   i_coef, i_coef_load            coefficient register load
//   o_y, o_valid_out, o_ready_in   result output handshake
//   o_busy                         some stage holds valid data
//
// Build option: define COEF_MULT_SAT_EN to saturate results wider than OUT_WIDTH
// to all ones; otherwise the product wraps to its low OUT_WIDTH bits.
module coef_mult_pipe
    import quad_pkg::*;
#(
    parameter int               WIDTH     = DATA_WIDTH,
    parameter int               OUT_WIDTH = DATA_WIDTH,
    parameter int               LATENCY   = 2,
    parameter logic [WIDTH-1:0] COEF_INIT = WIDTH'(COEF_A)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     i_x,
    input  logic                 i_valid_in,
    output logic                 i_ready_out,
    input  logic [WIDTH-1:0]     i_coef,
    input  logic                 i_coef_load,
    output logic [OUT_WIDTH-1:0] o_y,
    output logic                 o_valid_out,
    input  logic                 o_ready_in,
    output logic                 o_busy
);

    logic [WIDTH-1:0]     coef;
    logic [2*WIDTH-1:0]   prod_full;
    logic [OUT_WIDTH-1:0] prod_res;

    logic [LATENCY-1:0]   stg_vld;
    logic [LATENCY-1:0]   stg_load;
    logic [OUT_WIDTH-1:0] stg_dat [LATENCY];

    // Coefficient register. An operand accepted on the load edge still sees
    // the old value because stage 0 samples the product of the current coef.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef <= COEF_INIT;
        end else if (i_coef_load) begin
            coef <= i_coef;
        end
    end

    assign prod_full = {{WIDTH{1'b0}}, i_x} * {{WIDTH{1'b0}}, coef};

    // The shift form stays legal when OUT_WIDTH == 2*WIDTH (result is then zero,
    // so both builds agree).
`ifdef COEF_MULT_SAT_EN
    assign prod_res = ((prod_full >> OUT_WIDTH) != '0) ? '1 : OUT_WIDTH'(prod_full);
`else
    assign prod_res = OUT_WIDTH'(prod_full);
`endif

    genvar k;
    generate
        for (k = 0; k < LATENCY; k++) begin : g_stage
            logic [OUT_WIDTH-1:0] d_dat;
            logic                 d_vld;
            logic                 nxt_load;

            if (k == 0) begin : g_head
                assign d_dat = prod_res;
                assign d_vld = i_valid_in;
            end else begin : g_body
                assign d_dat = stg_dat[k-1];
                assign d_vld = stg_vld[k-1];
            end

            if (k == LATENCY - 1) begin : g_tail
                assign nxt_load = o_ready_in;
            end else begin : g_link
                assign nxt_load = stg_load[k+1];
            end

            pipe_stage #(
                .W (OUT_WIDTH)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .d_dat    (d_dat),
                .d_vld    (d_vld),
                .nxt_load (nxt_load),
                .load     (stg_load[k]),
                .q_vld    (stg_vld[k]),
                .q_dat    (stg_dat[k])
            );
        end
    endgenerate

    assign i_ready_out = stg_load[0];
    assign o_y         = stg_dat[LATENCY-1];
    assign o_valid_out = stg_vld[LATENCY-1];
    assign o_busy      = |stg_vld;

endmodule

// File: tb/tb_coef_mult_pipe.sv
module tb_coef_mult_pipe;

    logic        clk;
    logic        rst_n;
    logic [15:0] x      [2];
    logic [15:0] coef_in[2];
    logic [15:0] y      [2];
    logic        vld    [2];
    logic        rdy    [2];
    logic        cload  [2];
    logic        ov     [2];
    logic        ordy   [2];
    logic        busy   [2];

    int total = 0;
    int bad   = 0;

    // Reference model state: outstanding results per instance, in order.
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] mcoef    [2];
    logic        hold_chk [2];
    logic [15:0] prev_y   [2];
    logic        acc_last [2];

    coef_mult_pipe u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_x(x[0]), .i_valid_in(vld[0]), .i_ready_out(rdy[0]),
        .i_coef(coef_in[0]), .i_coef_load(cload[0]),
        .o_y(y[0]), .o_valid_out(ov[0]), .o_ready_in(ordy[0]), .o_busy(busy[0])
    );

    coef_mult_pipe #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_x(x[1]), .i_valid_in(vld[1]), .i_ready_out(rdy[1]),
        .i_coef(coef_in[1]), .i_coef_load(cload[1]),
        .o_y(y[1]), .o_valid_out(ov[1]), .o_ready_in(ordy[1]), .o_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // Unsigned full product, then wrap or saturate to 16 bits.
    function automatic logic [15:0] model_prod(input logic [15:0] a, input logic [15:0] c);
        longint unsigned p;
        p = longint'(a) * longint'(c);
`ifdef COEF_MULT_SAT_EN
        if (p > 64'd65535) return 16'hFFFF;
`endif
        return 16'(p);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [15:0] qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check both instances against the model just before the edge, advance the
    // model by the transfers that edge performs, then move to the next negedge.
    task automatic step();
        #1;
        for (int d = 0; d < 2; d++) begin
            logic rexp;
            logic acc;
            logic outx;
            rexp = (qsize(d) < lat(d)) || ordy[d];
            chk("ready", {31'd0, rdy[d]}, {31'd0, rexp});
            chk("busy", {31'd0, busy[d]}, {31'd0, qsize(d) != 0});
            chk("no_stale_out", {31'd0, (qsize(d) != 0) || !ov[d]}, 32'd1);
            if (hold_chk[d]) begin
                chk("stall_valid", {31'd0, ov[d]}, 32'd1);
                chk("stall_y", {16'd0, y[d]}, {16'd0, prev_y[d]});
            end
            if (ov[d] && qsize(d) != 0) begin
                chk("y_order", {16'd0, y[d]}, {16'd0, qfront(d)});
            end
            outx = ov[d] && ordy[d];
            acc  = vld[d] && rexp;
            if (outx && qsize(d) != 0) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (acc) begin
                if (d == 0) q0.push_back(model_prod(x[d], mcoef[d]));
                else        q1.push_back(model_prod(x[d], mcoef[d]));
            end
            if (cload[d]) mcoef[d] = coef_in[d];
            hold_chk[d] = ov[d] && !ordy[d];
            prev_y[d]   = y[d];
            acc_last[d] = acc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            mcoef[d]    = 16'd101;
            hold_chk[d] = 1'b0;
            acc_last[d] = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] sat_exp;
        int nacc;
        int guard;
`ifdef COEF_MULT_SAT_EN
        sat_exp = 16'd65535;
`else
        sat_exp = 16'd35464;
`endif
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            x[d] = '0; coef_in[d] = '0; vld[d] = 1'b0; cload[d] = 1'b0; ordy[d] = 1'b1;
        end
        model_reset();

        // Reset state
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_y", {16'd0, y[d]}, 32'd0);
            chk("rst_valid", {31'd0, ov[d]}, 32'd0);
            chk("rst_busy", {31'd0, busy[d]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", {31'd0, rdy[0]}, 32'd1);

        // Single operand, latency 2
        x[0] = 16'd3; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk("lat_early", {31'd0, ov[0]}, 32'd0);
        step();
        chk("lat_valid", {31'd0, ov[0]}, 32'd1);
        chk("lat_y", {16'd0, y[0]}, 32'd303);
        step();
        chk("lat_pulse_once", {31'd0, ov[0]}, 32'd0);

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            x[0] = 16'(i + 1); vld[0] = 1'b1;
            chk("stream_ready", {31'd0, rdy[0]}, 32'd1);
            step();
            if (i >= 1) begin
                chk("stream_valid", {31'd0, ov[0]}, 32'd1);
                chk("stream_y", {16'd0, y[0]}, 32'(101 * i));
            end
        end
        vld[0] = 1'b0;
        step();
        chk("stream_last", {16'd0, y[0]}, 32'd404);
        step();

        // Wide product: wrap or saturate
        x[0] = 16'd1000; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        step();
        chk("wide_valid", {31'd0, ov[0]}, 32'd1);
        chk("wide_y", {16'd0, y[0]}, {16'd0, sat_exp});
        step();

        // Coefficient load on the accept edge uses the old value
        x[0] = 16'd2; vld[0] = 1'b1; coef_in[0] = 16'd59; cload[0] = 1'b1;
        step();
        cload[0] = 1'b0;
        step();
        vld[0] = 1'b0;
        chk("coef_old", {16'd0, y[0]}, 32'd202);
        step();
        chk("coef_new", {16'd0, y[0]}, 32'd118);
        step();

        // Full-pipe stall on the latency-3 instance
        ordy[1] = 1'b0; vld[1] = 1'b1; x[1] = 16'd10;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc_last[1]) begin
                nacc++;
                x[1] = x[1] + 16'd1;
            end
        end
        chk("stall_accepts", 32'(nacc), 32'd3);
        #1;
        chk("stall_ready_low", {31'd0, rdy[1]}, 32'd0);
        chk("stall_out_valid", {31'd0, ov[1]}, 32'd1);
        chk("stall_out_y", {16'd0, y[1]}, 32'd1010);
        repeat (3) step();
        ordy[1] = 1'b1;
        guard = 0;
        while (x[1] != 16'd15 && guard < 20) begin
            step();
            if (acc_last[1]) x[1] = x[1] + 16'd1;
            guard++;
        end
        chk("stall_all_offered", {16'd0, x[1]}, 32'd15);
        vld[1] = 1'b0;
        guard = 0;
        while (q1.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("stall_drained", 32'(q1.size()), 32'd0);

        // Randomized traffic with backpressure and coefficient reloads
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!(vld[d] && !acc_last[d])) begin
                    vld[d] = ($urandom_range(0, 3) != 0);
                    x[d]   = 16'($urandom);
                end
                ordy[d]    = ($urandom_range(0, 3) != 0);
                cload[d]   = ($urandom_range(0, 15) == 0);
                coef_in[d] = (c % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0; cload[d] = 1'b0; ordy[d] = 1'b1;
        end
        repeat (5) step();
        chk("rand_drained0", 32'(q0.size()), 32'd0);
        chk("rand_drained1", 32'(q1.size()), 32'd0);

        // Asynchronous reset with data in flight
        for (int d = 0; d < 2; d++) begin
            ordy[d] = 1'b0; vld[d] = 1'b1; x[d] = 16'd7;
        end
        repeat (4) step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("arst_valid", {31'd0, ov[d]}, 32'd0);
            chk("arst_busy", {31'd0, busy[d]}, 32'd0);
        end
        model_reset();
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0; ordy[d] = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        x[0] = 16'd1; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        step();
        chk("arst_coef_valid", {31'd0, ov[0]}, 32'd1);
        chk("arst_coef_y", {16'd0, y[0]}, 32'd101);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
